desc_dispatcher: RTL and testbench

DESC_DISPATCHER -- requirements
Module: desc_dispatcher

---
 rtl/desc_dispatcher_pkg.sv | 17 +
 rtl/desc_dispatcher_rr_arbiter.sv | 30 +++
 rtl/desc_dispatcher.sv | 160 ++++++++++++++++
 tb/tb_desc_dispatcher.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/desc_dispatcher_pkg.sv
// Shared definitions for the descriptor dispatcher: beat field layout and FSM state encoding.
package desc_dispatcher_pkg;

  localparam int unsigned PAYLOAD_WIDTH = 992;
  localparam int unsigned PAYLOAD_LSB   = 0;
  localparam int unsigned PAYLOAD_MSB   = 991;
  localparam int unsigned PASID_LSB     = 992;
  localparam int unsigned PASID_MSB     = 1000;
  localparam int unsigned VALID_BIT     = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2
  } disp_state_t;

endpackage

// File: rtl/desc_dispatcher_rr_arbiter.sv
// Combinational round-robin selector: first requester at or after ptr wins (wrapping).
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/desc_dispatcher.sv
// Pulls descriptors from a FWFT FIFO, issues valid ones round-robin to idle engines and
// reports engine completions lowest-index first. DESC_DISPATCHER_STATS_EN adds issue/drop counters.
module desc_dispatcher
  import desc_dispatcher_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 1024,
  parameter int unsigned PASID_WIDTH = 9,
  parameter int unsigned NUM_ENGINES = 4,
  parameter int unsigned JOBID_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dsc_ready_i,
  input  logic [DATA_WIDTH-1:0]    dsc_data_i,
  output logic                     dsc_pull_o,
  output logic [NUM_ENGINES-1:0]   eng_valid_o,
  input  logic [NUM_ENGINES-1:0]   eng_ready_i,
  output logic [PAYLOAD_WIDTH-1:0] eng_data_o,
  output logic [PASID_WIDTH-1:0]   eng_pasid_o,
  output logic [JOBID_WIDTH-1:0]   eng_jobid_o,
  input  logic [NUM_ENGINES-1:0]   eng_done_i,
  output logic                     cmpl_valid_o,
  output logic [2:0]               cmpl_engine_o,
  output logic [JOBID_WIDTH-1:0]   cmpl_jobid_o,
  output logic [PASID_WIDTH-1:0]   cmpl_pasid_o,
`ifdef DESC_DISPATCHER_STATS_EN
  output logic [31:0]              stat_issued_o,
  output logic [31:0]              stat_dropped_o,
`endif
  output logic                     idle_o
);

  localparam int unsigned IW = $clog2(NUM_ENGINES);

  disp_state_t              state;
  logic [PAYLOAD_WIDTH-1:0] hold_payload;
  logic [PASID_WIDTH-1:0]   hold_pasid;
  logic [IW-1:0]            sel_idx;
  logic [IW-1:0]            rr_ptr;
  logic [JOBID_WIDTH-1:0]   job_id;
  logic [NUM_ENGINES-1:0]   busy;
  logic [NUM_ENGINES-1:0]   pending;
  logic [JOBID_WIDTH-1:0]   job_tab   [NUM_ENGINES];
  logic [PASID_WIDTH-1:0]   pasid_tab [NUM_ENGINES];

  logic [NUM_ENGINES-1:0]   arb_grant;
  logic [IW-1:0]            arb_idx;
  logic                     arb_any;
  logic                     handshake;
  logic                     cmpl_hit;
  logic [IW-1:0]            cmpl_idx;
  logic [IW-1:0]            scan;
  logic [NUM_ENGINES-1:0]   clr;
  logic [NUM_ENGINES-1:0]   busy_next;
  logic [NUM_ENGINES-1:0]   pending_next;
  logic                     unused_bits;

  assign unused_bits = ^{dsc_data_i[DATA_WIDTH-1:PASID_MSB+1], arb_any};

  rr_arbiter #(.N(NUM_ENGINES), .IW(IW)) u_arb (
    .req   (~busy),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign dsc_pull_o  = !rst && (state == ST_IDLE) && dsc_ready_i && !(&busy);
  assign handshake   = (state == ST_ISSUE) && eng_ready_i[sel_idx];
  assign eng_data_o  = hold_payload;
  assign eng_pasid_o = hold_pasid;
  assign eng_jobid_o = job_id;
  assign idle_o      = (state == ST_IDLE) && (busy == '0) && (pending == '0);

  // Lowest pending engine is reported and freed at the same edge.
  always_comb begin
    cmpl_hit = 1'b0;
    cmpl_idx = '0;
    scan     = '0;
    clr      = '0;
    for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
      scan = IW'(k);
      if (!cmpl_hit && pending[scan]) begin
        cmpl_hit  = 1'b1;
        cmpl_idx  = scan;
        clr[scan] = 1'b1;
      end
    end
    busy_next    = (busy | (handshake ? eng_valid_o : '0)) & ~clr;
    pending_next = (pending | (eng_done_i & busy)) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      hold_payload   <= '0;
      hold_pasid     <= '0;
      sel_idx        <= '0;
      rr_ptr         <= '0;
      job_id         <= '0;
      busy           <= '0;
      pending        <= '0;
      eng_valid_o    <= '0;
      cmpl_valid_o   <= 1'b0;
      cmpl_engine_o  <= '0;
      cmpl_jobid_o   <= '0;
      cmpl_pasid_o   <= '0;
`ifdef DESC_DISPATCHER_STATS_EN
      stat_issued_o  <= '0;
      stat_dropped_o <= '0;
`endif
    end else begin
      busy         <= busy_next;
      pending      <= pending_next;
      cmpl_valid_o <= cmpl_hit;
      if (cmpl_hit) begin
        cmpl_engine_o <= 3'(cmpl_idx);
        cmpl_jobid_o  <= job_tab[cmpl_idx];
        cmpl_pasid_o  <= pasid_tab[cmpl_idx];
      end
      case (state)
        ST_IDLE: begin
          if (dsc_pull_o) begin
            hold_payload <= dsc_data_i[PAYLOAD_MSB:PAYLOAD_LSB];
            hold_pasid   <= dsc_data_i[PASID_LSB +: PASID_WIDTH];
            state        <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!hold_payload[VALID_BIT]) begin
            state <= ST_IDLE;
`ifdef DESC_DISPATCHER_STATS_EN
            if (stat_dropped_o != '1) stat_dropped_o <= stat_dropped_o + 32'd1;
`endif
          end else begin
            // Busy only grows in ISSUE, so the engine free at pull time is still free here.
            sel_idx     <= arb_idx;
            eng_valid_o <= arb_grant;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (handshake) begin
            job_tab[sel_idx]   <= job_id;
            pasid_tab[sel_idx] <= hold_pasid;
            job_id             <= job_id + 1'b1;
            rr_ptr             <= (sel_idx == IW'(NUM_ENGINES - 1)) ? '0 : sel_idx + 1'b1;
            eng_valid_o        <= '0;
            state              <= ST_IDLE;
`ifdef DESC_DISPATCHER_STATS_EN
            if (stat_issued_o != '1) stat_issued_o <= stat_issued_o + 32'd1;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_desc_dispatcher.sv
// Directed self-checking bench for desc_dispatcher (default parameters, 4 engines).
module tb_desc_dispatcher;

  logic          clk = 1'b0;
  logic          rst;
  logic          dsc_ready_i;
  logic [1023:0] dsc_data_i;
  logic          dsc_pull_o;
  logic [3:0]    eng_valid_o;
  logic [3:0]    eng_ready_i;
  logic [991:0]  eng_data_o;
  logic [8:0]    eng_pasid_o;
  logic [15:0]   eng_jobid_o;
  logic [3:0]    eng_done_i;
  logic          cmpl_valid_o;
  logic [2:0]    cmpl_engine_o;
  logic [15:0]   cmpl_jobid_o;
  logic [8:0]    cmpl_pasid_o;
  logic          idle_o;
`ifdef DESC_DISPATCHER_STATS_EN
  logic [31:0]   stat_issued_o;
  logic [31:0]   stat_dropped_o;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  desc_dispatcher #(
    .DATA_WIDTH  (1024),
    .PASID_WIDTH (9),
    .NUM_ENGINES (4),
    .JOBID_WIDTH (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dsc_ready_i   (dsc_ready_i),
    .dsc_data_i    (dsc_data_i),
    .dsc_pull_o    (dsc_pull_o),
    .eng_valid_o   (eng_valid_o),
    .eng_ready_i   (eng_ready_i),
    .eng_data_o    (eng_data_o),
    .eng_pasid_o   (eng_pasid_o),
    .eng_jobid_o   (eng_jobid_o),
    .eng_done_i    (eng_done_i),
    .cmpl_valid_o  (cmpl_valid_o),
    .cmpl_engine_o (cmpl_engine_o),
    .cmpl_jobid_o  (cmpl_jobid_o),
    .cmpl_pasid_o  (cmpl_pasid_o),
`ifdef DESC_DISPATCHER_STATS_EN
    .stat_issued_o (stat_issued_o),
    .stat_dropped_o(stat_dropped_o),
`endif
    .idle_o        (idle_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] mk(input logic [8:0] pasid, input logic valid,
                                       input logic [15:0] tag);
    logic [1023:0] d;
    d           = '0;
    d[0]        = valid;
    d[16:1]     = tag;
    d[1000:992] = pasid;
    return d;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    dsc_ready_i = 1'b0;
    eng_ready_i = '0;
    eng_done_i  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Full pull/load/issue sequence with an always-ready engine set.
  task automatic issue_one(input logic [8:0] pasid, input logic [15:0] tag,
                           input logic [3:0] exp_eng, input logic [15:0] exp_job);
    dsc_ready_i = 1'b1;
    dsc_data_i  = mk(pasid, 1'b1, tag);
    eng_ready_i = '1;
    #1 check("issue_pull", dsc_pull_o, 1);
    tick();
    dsc_ready_i = 1'b0;
    #1 check("load_nopull", dsc_pull_o, 0);
    tick();
    check("issue_valid", eng_valid_o, exp_eng);
    check("issue_jobid", eng_jobid_o, exp_job);
    check("issue_pasid", eng_pasid_o, pasid);
    check("issue_data", eng_data_o[16:1], tag);
    tick();
    check("issue_done", eng_valid_o, 0);
    eng_ready_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dsc_data_i = '0;
    do_reset();
    rst = 1'b1;
    tick();
    check("rst_valid", eng_valid_o, 0);
    check("rst_cmpl", cmpl_valid_o, 0);
    check("rst_pull", dsc_pull_o, 0);
    check("rst_idle", idle_o, 1);
    rst = 1'b0;
    tick();

    // Single descriptor, PASID 5, through to completion.
    issue_one(9'd5, 16'h00ab, 4'b0001, 16'd0);
    check("single_notidle", idle_o, 0);
    eng_done_i = 4'b0001;
    tick();
    eng_done_i = '0;
    check("single_cmpl_lat", cmpl_valid_o, 0);
    tick();
    check("single_cmpl", cmpl_valid_o, 1);
    check("single_eng", cmpl_engine_o, 0);
    check("single_job", cmpl_jobid_o, 0);
    check("single_pasid", cmpl_pasid_o, 5);
    tick();
    check("single_cmpl_end", cmpl_valid_o, 0);
    check("single_idle", idle_o, 1);

    // Five descriptors, no completions: round-robin 0..3, fifth waits.
    do_reset();
    tick();
    for (int i = 0; i < 4; i++)
      issue_one(9'(10 + i), 16'(i), 4'(1 << i), 16'(i));
    dsc_ready_i = 1'b1;
    dsc_data_i  = mk(9'd14, 1'b1, 16'd4);
    for (int i = 0; i < 3; i++) begin
      #1 check("full_nopull", dsc_pull_o, 0);
      tick();
    end
    eng_done_i = 4'b0100;
    tick();
    eng_done_i = '0;
    check("full_nopull_pend", dsc_pull_o, 0);
    tick();
    check("free_cmpl", cmpl_valid_o, 1);
    check("free_eng", cmpl_engine_o, 2);
    check("free_job", cmpl_jobid_o, 2);
    check("free_pull", dsc_pull_o, 1);
    tick();
    dsc_ready_i = 1'b0;
    eng_ready_i = '1;
    tick();
    check("fifth_valid", eng_valid_o, 4'b0100);
    check("fifth_job", eng_jobid_o, 4);
    check("fifth_pasid", eng_pasid_o, 14);
    tick();
    eng_ready_i = '0;
    check("fifth_done", eng_valid_o, 0);

    // Ten-cycle stall, then an invalid descriptor is dropped.
    do_reset();
    tick();
    dsc_ready_i = 1'b1;
    dsc_data_i  = mk(9'd7, 1'b1, 16'h0055);
    tick();
    tick();
    eng_ready_i = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("stall_valid", eng_valid_o, 4'b0001);
      check("stall_job", eng_jobid_o, 0);
      check("stall_pasid", eng_pasid_o, 7);
      check("stall_data", eng_data_o[16:1], 16'h0055);
      check("stall_nopull", dsc_pull_o, 0);
      tick();
    end
    eng_ready_i = 4'b0001;
    dsc_data_i  = mk(9'd8, 1'b0, 16'h0077);
    tick();
    eng_ready_i = '0;
    check("stall_release", eng_valid_o, 0);
    check("next_pull", dsc_pull_o, 1);
    tick();
    dsc_ready_i = 1'b0;
    tick();
    check("drop_novalid", eng_valid_o, 0);
    tick();
    check("drop_novalid2", eng_valid_o, 0);
    check("drop_notidle", idle_o, 0);
`ifdef DESC_DISPATCHER_STATS_EN
    check("stat_issued", stat_issued_o, 1);
    check("stat_dropped", stat_dropped_o, 1);
`endif

    // Simultaneous completions on engines 0, 1 and 3.
    do_reset();
    tick();
    for (int i = 0; i < 4; i++)
      issue_one(9'(20 + i), 16'(100 + i), 4'(1 << i), 16'(i));
    eng_done_i = 4'b1011;
    tick();
    eng_done_i = '0;
    check("multi_lat", cmpl_valid_o, 0);
    tick();
    check("multi0_v", cmpl_valid_o, 1);
    check("multi0_eng", cmpl_engine_o, 0);
    check("multi0_job", cmpl_jobid_o, 0);
    check("multi0_pasid", cmpl_pasid_o, 20);
    tick();
    check("multi1_v", cmpl_valid_o, 1);
    check("multi1_eng", cmpl_engine_o, 1);
    check("multi1_job", cmpl_jobid_o, 1);
    tick();
    check("multi3_v", cmpl_valid_o, 1);
    check("multi3_eng", cmpl_engine_o, 3);
    check("multi3_job", cmpl_jobid_o, 3);
    check("multi3_pasid", cmpl_pasid_o, 23);
    tick();
    check("multi_end", cmpl_valid_o, 0);
    eng_done_i = 4'b0001;
    tick();
    eng_done_i = '0;
    tick();
    check("stray_done", cmpl_valid_o, 0);
    tick();
    check("stray_done2", cmpl_valid_o, 0);
    check("stray_notidle", idle_o, 0);

    // Reset during ISSUE with engines 0 and 2 busy.
    issue_one(9'd30, 16'h0300, 4'b0001, 16'd4);
    dsc_ready_i = 1'b1;
    dsc_data_i  = mk(9'd31, 1'b1, 16'h0301);
    tick();
    dsc_ready_i = 1'b1;
    tick();
    check("pre_rst_valid", eng_valid_o, 4'b0010);
    check("pre_rst_job", eng_jobid_o, 5);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", eng_valid_o, 0);
    check("mid_rst_cmpl", cmpl_valid_o, 0);
    check("mid_rst_pull", dsc_pull_o, 0);
    check("mid_rst_idle", idle_o, 1);
    rst = 1'b0;
    dsc_ready_i = 1'b0;
    eng_done_i  = 4'b0101;
    tick();
    eng_done_i = '0;
    for (int i = 0; i < 3; i++) begin
      check("post_rst_nocmpl", cmpl_valid_o, 0);
      tick();
    end
    check("post_rst_idle", idle_o, 1);
    issue_one(9'd40, 16'h0400, 4'b0001, 16'd0);
`ifdef DESC_DISPATCHER_STATS_EN
    check("post_rst_issued", stat_issued_o, 1);
    check("post_rst_dropped", stat_dropped_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
